// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle Hack ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    FN   = 2'd2,
    POST = 2'd3
  } state_t;

  // Bit positions inside the 6-bit control word {zx,nx,zy,ny,f,no}
  localparam int unsigned CTRL_ZX = 5;
  localparam int unsigned CTRL_NX = 4;
  localparam int unsigned CTRL_ZY = 3;
  localparam int unsigned CTRL_NY = 2;
  localparam int unsigned CTRL_F  = 1;
  localparam int unsigned CTRL_NO = 0;

  // Commonly used Hack opcodes
  localparam logic [5:0] OP_ZERO      = 6'b101010;
  localparam logic [5:0] OP_X_PLUS_Y  = 6'b000010;
  localparam logic [5:0] OP_NOT_X     = 6'b001101;
  localparam logic [5:0] OP_X_MINUS_Y = 6'b010011;

endpackage

// File: rtl/Not16.sv
// 16-bit bitwise inverter gate.
module Not16 (
  input  logic [15:0] in,
  output logic [15:0] out
);

  assign out = ~in;

endmodule

// File: rtl/alu_operand_prep.sv
// Operand conditioning: optional zeroing followed by optional inversion.
module alu_operand_prep #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             zero_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  logic [WIDTH-1:0] zeroed;
  logic [WIDTH-1:0] inverted;

  assign zeroed = zero_i ? '0 : val_i;

  // Only the native 16-bit width is wired to the Not16 gate
  generate
    if (WIDTH == 16) begin : g_not16
      Not16 u_not (
        .in  (zeroed),
        .out (inverted)
      );
    end else begin : g_not_generic
      assign inverted = ~zeroed;
    end
  endgenerate

  // Select inverted or plain zero-conditioned operand
  always_comb begin
    res_o = neg_i ? inverted : zeroed;
  end

endmodule

// File: rtl/alu16_mc.sv
// Multi-cycle Hack ALU: PRE (operand conditioning), FN (add/and),
// POST (output inversion and flags), with registered result and flags.
module alu16_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [5:0]       ctrl_q;
  logic [WIDTH-1:0] xa_q, ya_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] out_q;
  logic             zr_q, ng_q, busy_q, done_q;

  logic [WIDTH-1:0] xa_d, ya_d;
  logic [WIDTH-1:0] r_inv;
  logic [WIDTH-1:0] out_d;

  alu_operand_prep #(.WIDTH(WIDTH)) u_prep_x (
    .val_i  (x_q),
    .zero_i (ctrl_q[CTRL_ZX]),
    .neg_i  (ctrl_q[CTRL_NX]),
    .res_o  (xa_d)
  );

  alu_operand_prep #(.WIDTH(WIDTH)) u_prep_y (
    .val_i  (y_q),
    .zero_i (ctrl_q[CTRL_ZY]),
    .neg_i  (ctrl_q[CTRL_NY]),
    .res_o  (ya_d)
  );

  generate
    if (WIDTH == 16) begin : g_not16
      Not16 u_not_out (
        .in  (r_q),
        .out (r_inv)
      );
    end else begin : g_not_generic
      assign r_inv = ~r_q;
    end
  endgenerate

  // Output conditioning applied to the function result
  always_comb begin
    out_d = ctrl_q[CTRL_NO] ? r_inv : r_q;
  end

  // Sequencer with registered datapath, result, flags and handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ctrl_q  <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      r_q     <= '0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            ctrl_q  <= ctrl;
            busy_q  <= 1'b1;
            state_q <= PRE;
          end
        end
        PRE: begin
          xa_q    <= xa_d;
          ya_q    <= ya_d;
          state_q <= FN;
        end
        FN: begin
          r_q     <= ctrl_q[CTRL_F] ? (xa_q + ya_q) : (xa_q & ya_q);
          state_q <= POST;
        end
        POST: begin
          out_q   <= out_d;
          zr_q    <= (out_d == '0);
          ng_q    <= out_d[WIDTH-1];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign zr   = zr_q;
  assign ng   = ng_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu16_mc.sv
// Self-checking bench for alu16_mc with a behavioural Hack ALU model.
module tb_alu16_mc;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic [15:0] out;
  logic        zr, ng, busy, done;

  int total;
  int bad;

  alu16_mc #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .ctrl  (ctrl),
    .out   (out),
    .zr    (zr),
    .ng    (ng),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the Hack ALU truth rules computed with plain arithmetic
  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] c);
    int unsigned xv, yv, rv;
    xv = c[5] ? 0 : int'(a);
    if (c[4]) xv = 16'hFFFF - xv;
    yv = c[3] ? 0 : int'(b);
    if (c[2]) yv = 16'hFFFF - yv;
    if (c[1]) rv = (xv + yv) % 65536;
    else      rv = xv & yv;
    if (c[0]) rv = 16'hFFFF - rv;
    return rv[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    x     = 16'd123;
    y     = 16'd456;
    ctrl  = OP_X_PLUS_Y;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({out, zr, ng, busy, done} !== 20'd0) begin
        bad++;
        $display("FAIL reset[%0d]: out=%h zr=%b ng=%b busy=%b done=%b, want all 0",
                 i, out, zr, ng, busy, done);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [15:0] xs[6];
    logic [15:0] ys[6];
    logic [5:0]  cs[6];
    logic [15:0] es[6];
    xs = '{16'd25, 16'd25, 16'd25, 16'd25, 16'h7FFF, 16'd0};
    ys = '{16'd4181, 16'd0, 16'd99, 16'd4181, 16'd1, 16'd0};
    cs = '{OP_X_PLUS_Y, OP_NOT_X, OP_ZERO, OP_X_MINUS_Y, OP_X_PLUS_Y, OP_X_PLUS_Y};
    es = '{16'd4206, 16'hFFE6, 16'h0000, 16'hEFC4, 16'h8000, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      x = xs[i]; y = ys[i]; ctrl = cs[i]; start = 1'b1;
      tick();
      start = 1'b0;
      x = 16'hDEAD; y = 16'hBEEF; ctrl = 6'b111111;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL dir%0d_busy%0d: busy=%b done=%b, want 1 0", i, k, busy, done);
        end
        if (k < 2) tick();
      end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== es[i] ||
          zr !== (es[i] == 16'd0) || ng !== es[i][15]) begin
        bad++;
        $display("FAIL dir%0d_result: out=%h zr=%b ng=%b done=%b busy=%b, want out=%h zr=%b ng=%b done=1 busy=0",
                 i, out, zr, ng, done, busy, es[i], es[i] == 16'd0, es[i][15]);
      end
      tick();
      total++;
      if (done !== 1'b0 || out !== es[i]) begin
        bad++;
        $display("FAIL dir%0d_hold: done=%b out=%h, want done=0 out=%h", i, done, out, es[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ex;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
      ex = ref_alu(x, y, ctrl);
      start = 1'b1;
      tick();
      start = 1'($urandom);
      x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
      tick();
      tick();
      start = 1'b0;
      tick();
      total++;
      if (done !== 1'b1 || out !== ex || zr !== (ex == 16'd0) || ng !== ex[15]) begin
        bad++;
        $display("FAIL rand%0d: out=%h zr=%b ng=%b done=%b, want out=%h zr=%b ng=%b done=1",
                 i, out, zr, ng, done, ex, ex == 16'd0, ex[15]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e1, e2;
    e1 = ref_alu(16'd1000, 16'd234, OP_X_MINUS_Y);
    e2 = ref_alu(16'h0F0F, 16'h00FF, 6'b000000);
    x = 16'd1000; y = 16'd234; ctrl = OP_X_MINUS_Y; start = 1'b1;
    tick();
    x = 16'd5; y = 16'd7; ctrl = OP_X_PLUS_Y;
    tick();
    tick();
    x = 16'h0F0F; y = 16'h00FF; ctrl = 6'b000000;
    tick();
    total++;
    if (done !== 1'b1 || out !== e1) begin
      bad++;
      $display("FAIL b2b_first: done=%b out=%h, want done=1 out=%h", done, out, e1);
    end
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || out !== e1) begin
      bad++;
      $display("FAIL b2b_accept: done=%b busy=%b out=%h, want done=0 busy=1 out=%h",
               done, busy, out, e1);
    end
    tick();
    tick();
    total++;
    if (done !== 1'b0 || out !== e1) begin
      bad++;
      $display("FAIL b2b_wait: done=%b out=%h, want done=0 out=%h", done, out, e1);
    end
    tick();
    total++;
    if (done !== 1'b1 || out !== e2 || zr !== (e2 == 16'd0) || ng !== e2[15]) begin
      bad++;
      $display("FAIL b2b_second: done=%b out=%h zr=%b ng=%b, want done=1 out=%h", done, out, zr, ng, e2);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [15:0] ex;
    x = 16'h1234; y = 16'h4321; ctrl = OP_X_PLUS_Y; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({out, zr, ng, busy, done} !== 20'd0) begin
      bad++;
      $display("FAIL abort_reset: out=%h zr=%b ng=%b busy=%b done=%b, want all 0",
               out, zr, ng, busy, done);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet%0d: done=%b busy=%b, want 0 0", k, done, busy);
      end
    end
    x = 16'd300; y = 16'd45; ctrl = OP_X_MINUS_Y; start = 1'b1;
    ex = ref_alu(x, y, ctrl);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (done !== 1'b1 || out !== ex || ng !== ex[15] || zr !== (ex == 16'd0)) begin
      bad++;
      $display("FAIL abort_recover: done=%b out=%h, want done=1 out=%h", done, out, ex);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    ctrl  = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
